// File: rtl/axis_egress_pkg.sv
// Shared types for the NoC egress drain stage: input filter states and
// the layout of one buffered beat.
package axis_egress_pkg;

  // Input filter state: waiting for a packet head, passing a packet, or
  // swallowing a packet addressed elsewhere.
  typedef enum logic [1:0] {
    HEAD = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } filter_state_t;

  localparam int DATAW_DEF = 512;
  localparam int USERW_DEF = 75;
  localparam int DESTW_DEF = 12;

  // One buffered beat at the default widths. The egress top uses the same
  // field order with its own parameterized widths.
  typedef struct packed {
    logic [DATAW_DEF-1:0] tdata;
    logic                 tlast;
    logic [USERW_DEF-1:0] tuser;
    logic [DESTW_DEF-1:0] tdest;
  } egress_entry_t;

  // Packed width of one buffered beat for arbitrary field widths.
  function automatic int entry_width(input int dataw, input int userw, input int destw);
    return dataw + 1 + userw + destw;
  endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with registered full/empty.
// Writes while full and reads while empty are ignored.
module axis_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic [CW-1:0]    count_next_s;
  logic             full_r;
  logic             empty_r;
  logic             wr_ok_s;
  logic             rd_ok_s;

  // Qualify requests against the flags and work out the next occupancy.
  always_comb begin
    wr_ok_s = wr_en & ~full_r;
    rd_ok_s = rd_en & ~empty_r;
    case ({wr_ok_s, rd_ok_s})
      2'b10:   count_next_s = count_r + CW'(1'b1);
      2'b01:   count_next_s = count_r - CW'(1'b1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy and flags; the pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      if (wr_ok_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end
      if (rd_ok_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == DEPTH_C);
      empty_r <= (count_next_s == {CW{1'b0}});
    end
  end

  // Storage array; contents need no reset because empty_r guards reads.
  always_ff @(posedge clk) begin
    if (wr_ok_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // Head of the queue is visible without a read request.
  always_comb begin
    rd_data = mem_r[rd_ptr_r];
    full    = full_r;
    empty   = empty_r;
  end

endmodule

// File: rtl/axis_noc_egress.sv
// Egress drain stage from a NoC tile output port to an AXI-Stream master.
// Whole packets addressed to LOCAL_DEST are buffered and forwarded with a
// packet sequence number on TID; all other packets are discarded whole.
module axis_noc_egress
  import axis_egress_pkg::*;
#(
  parameter int DATAW      = 512,
  parameter int USERW      = 75,
  parameter int DESTW      = 12,
  parameter int IDW        = 32,
  parameter int FIFOD      = 16,
  parameter int LOCAL_DEST = 0,
  parameter int CNTW       = 32
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             AXIS_S_TVALID,
  output logic             AXIS_S_TREADY,
  input  logic [DATAW-1:0] AXIS_S_TDATA,
  input  logic             AXIS_S_TLAST,
  input  logic [USERW-1:0] AXIS_S_TUSER,
  input  logic [DESTW-1:0] AXIS_S_TDEST,
  output logic             AXIS_M_TVALID,
  input  logic             AXIS_M_TREADY,
  output logic [DATAW-1:0] AXIS_M_TDATA,
  output logic             AXIS_M_TLAST,
  output logic [IDW-1:0]   AXIS_M_TID,
  output logic [USERW-1:0] AXIS_M_TUSER,
  output logic [DESTW-1:0] AXIS_M_TDEST,
  output logic [CNTW-1:0]  PKT_CNT,
  output logic [CNTW-1:0]  DROP_CNT
);

  localparam int ENTW = entry_width(DATAW, USERW, DESTW);

  // Buffered beat, same field order as egress_entry_t.
  typedef struct packed {
    logic [DATAW-1:0] tdata;
    logic             tlast;
    logic [USERW-1:0] tuser;
    logic [DESTW-1:0] tdest;
  } entry_t;

  filter_state_t   state_r;
  logic            ready_en_r;
  logic [CNTW-1:0] drop_cnt_r;
  logic [CNTW-1:0] pkt_cnt_r;
  logic [IDW-1:0]  seq_r;
  logic [IDW-1:0]  seq_next_s;

  logic            m_valid_r;
  entry_t          m_entry_r;
  logic [IDW-1:0]  m_tid_r;

  logic            dest_match_s;
  logic            s_ready_s;
  logic            s_hs_s;
  logic            wr_en_s;
  logic            drop_done_s;
  logic            m_hs_s;
  logic            load_s;
  logic            fifo_full_s;
  logic            fifo_empty_s;
  entry_t          wr_entry_s;
  entry_t          rd_entry_s;

  // Input-side decode: ready, handshake, FIFO write and drop completion.
  always_comb begin
    dest_match_s = (AXIS_S_TDEST == DESTW'(LOCAL_DEST));
    case (state_r)
      DROP:    s_ready_s = ready_en_r;
      HEAD:    s_ready_s = ready_en_r & ~fifo_full_s;
      FWD:     s_ready_s = ready_en_r & ~fifo_full_s;
      default: s_ready_s = 1'b0;
    endcase
    s_hs_s = AXIS_S_TVALID & s_ready_s;
    case (state_r)
      HEAD: begin
        wr_en_s     = s_hs_s & dest_match_s;
        drop_done_s = s_hs_s & ~dest_match_s & AXIS_S_TLAST;
      end
      FWD: begin
        wr_en_s     = s_hs_s;
        drop_done_s = 1'b0;
      end
      DROP: begin
        wr_en_s     = 1'b0;
        drop_done_s = s_hs_s & AXIS_S_TLAST;
      end
      default: begin
        wr_en_s     = 1'b0;
        drop_done_s = 1'b0;
      end
    endcase
    wr_entry_s.tdata = AXIS_S_TDATA;
    wr_entry_s.tlast = AXIS_S_TLAST;
    wr_entry_s.tuser = AXIS_S_TUSER;
    wr_entry_s.tdest = AXIS_S_TDEST;
  end

  // Output-side decode. The TID loaded alongside a packet-closing handshake
  // must already reflect that packet's completion, hence seq_next_s.
  always_comb begin
    m_hs_s = m_valid_r & AXIS_M_TREADY;
    load_s = ~fifo_empty_s & (~m_valid_r | AXIS_M_TREADY);
    if (m_hs_s && m_entry_r.tlast) begin
      seq_next_s = seq_r + IDW'(1'b1);
    end else begin
      seq_next_s = seq_r;
    end
  end

  // Hold input ready low for the first cycle after reset release.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ready_en_r <= 1'b0;
    end else begin
      ready_en_r <= 1'b1;
    end
  end

  // Input filter FSM: decide at each head beat whether the packet is kept.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_r <= HEAD;
    end else if (s_hs_s) begin
      case (state_r)
        HEAD: begin
          if (AXIS_S_TLAST) begin
            state_r <= HEAD;
          end else if (dest_match_s) begin
            state_r <= FWD;
          end else begin
            state_r <= DROP;
          end
        end
        FWD: begin
          if (AXIS_S_TLAST) begin
            state_r <= HEAD;
          end
        end
        DROP: begin
          if (AXIS_S_TLAST) begin
            state_r <= HEAD;
          end
        end
        default: state_r <= HEAD;
      endcase
    end
  end

  // Count packets discarded whole.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      drop_cnt_r <= {CNTW{1'b0}};
    end else if (drop_done_s) begin
      drop_cnt_r <= drop_cnt_r + CNTW'(1'b1);
    end
  end

  axis_sync_fifo #(
    .WIDTH (ENTW),
    .DEPTH (FIFOD)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RST_N),
    .wr_en   (wr_en_s),
    .wr_data (wr_entry_s),
    .rd_en   (load_s),
    .rd_data (rd_entry_s),
    .full    (fifo_full_s),
    .empty   (fifo_empty_s)
  );

  // Output register stage, sequence counter and forwarded-packet counter.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      m_valid_r <= 1'b0;
      m_entry_r <= '0;
      m_tid_r   <= {IDW{1'b0}};
      seq_r     <= {IDW{1'b0}};
      pkt_cnt_r <= {CNTW{1'b0}};
    end else begin
      if (load_s) begin
        m_valid_r <= 1'b1;
        m_entry_r <= rd_entry_s;
        m_tid_r   <= seq_next_s;
      end else if (m_hs_s) begin
        m_valid_r <= 1'b0;
      end
      seq_r <= seq_next_s;
      if (m_hs_s && m_entry_r.tlast) begin
        pkt_cnt_r <= pkt_cnt_r + CNTW'(1'b1);
      end
    end
  end

  // Drive ports from the registered state.
  always_comb begin
    AXIS_S_TREADY = s_ready_s;
    AXIS_M_TVALID = m_valid_r;
    AXIS_M_TDATA  = m_entry_r.tdata;
    AXIS_M_TLAST  = m_entry_r.tlast;
    AXIS_M_TUSER  = m_entry_r.tuser;
    AXIS_M_TDEST  = m_entry_r.tdest;
    AXIS_M_TID    = m_tid_r;
    PKT_CNT       = pkt_cnt_r;
    DROP_CNT      = drop_cnt_r;
  end

endmodule

// File: tb/tb_axis_noc_egress.sv
// Self-checking bench for axis_noc_egress: directed scenarios plus a
// randomized packet stream, checked against a packet-level model.
module tb_axis_noc_egress;

  localparam int DATAW = 32;
  localparam int USERW = 8;
  localparam int DESTW = 12;
  localparam int IDW   = 4;
  localparam int FIFOD = 16;
  localparam int LD    = 3;
  localparam int CNTW  = 16;

  logic             CLK;
  logic             RST_N;
  logic             AXIS_S_TVALID;
  logic             AXIS_S_TREADY;
  logic [DATAW-1:0] AXIS_S_TDATA;
  logic             AXIS_S_TLAST;
  logic [USERW-1:0] AXIS_S_TUSER;
  logic [DESTW-1:0] AXIS_S_TDEST;
  logic             AXIS_M_TVALID;
  logic             AXIS_M_TREADY;
  logic [DATAW-1:0] AXIS_M_TDATA;
  logic             AXIS_M_TLAST;
  logic [IDW-1:0]   AXIS_M_TID;
  logic [USERW-1:0] AXIS_M_TUSER;
  logic [DESTW-1:0] AXIS_M_TDEST;
  logic [CNTW-1:0]  PKT_CNT;
  logic [CNTW-1:0]  DROP_CNT;

  axis_noc_egress #(
    .DATAW(DATAW), .USERW(USERW), .DESTW(DESTW), .IDW(IDW),
    .FIFOD(FIFOD), .LOCAL_DEST(LD), .CNTW(CNTW)
  ) dut (
    .CLK(CLK), .RST_N(RST_N),
    .AXIS_S_TVALID(AXIS_S_TVALID), .AXIS_S_TREADY(AXIS_S_TREADY),
    .AXIS_S_TDATA(AXIS_S_TDATA), .AXIS_S_TLAST(AXIS_S_TLAST),
    .AXIS_S_TUSER(AXIS_S_TUSER), .AXIS_S_TDEST(AXIS_S_TDEST),
    .AXIS_M_TVALID(AXIS_M_TVALID), .AXIS_M_TREADY(AXIS_M_TREADY),
    .AXIS_M_TDATA(AXIS_M_TDATA), .AXIS_M_TLAST(AXIS_M_TLAST),
    .AXIS_M_TID(AXIS_M_TID), .AXIS_M_TUSER(AXIS_M_TUSER),
    .AXIS_M_TDEST(AXIS_M_TDEST), .PKT_CNT(PKT_CNT), .DROP_CNT(DROP_CNT)
  );

  typedef struct packed {
    logic [DATAW-1:0] data;
    logic             last;
    logic [USERW-1:0] user;
    logic [DESTW-1:0] dest;
    logic [IDW-1:0]   tid;
  } beat_t;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model state
  beat_t          exp_q[$];
  logic [IDW-1:0] obs_tid[$];
  logic           in_pkt;
  logic           keep;
  logic [IDW-1:0] fwd_tid;
  logic [CNTW-1:0] exp_pkt;
  logic [CNTW-1:0] exp_drop;
  logic           prev_stall;
  beat_t          prev_snap;
  beat_t          cur_m;
  beat_t          e;

  logic rand_mode;
  logic rand_ready;
  logic m_fixed;
  assign AXIS_M_TREADY = rand_mode ? rand_ready : m_fixed;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp_v, $time);
    end
  endtask

  always @(negedge CLK) rand_ready = ($urandom_range(0, 3) != 0);

  // Packet-level model: S acceptance decides what must appear on M.
  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      exp_q.delete();
      in_pkt = 1'b0;
      keep = 1'b0;
      fwd_tid = '0;
      exp_pkt = '0;
      exp_drop = '0;
      prev_stall = 1'b0;
    end else begin
      cur_m = {AXIS_M_TDATA, AXIS_M_TLAST, AXIS_M_TUSER, AXIS_M_TDEST, AXIS_M_TID};
      if (prev_stall) check("m_stable", cur_m, prev_snap);
      if (AXIS_M_TVALID) begin
        if (exp_q.size() == 0) begin
          check("m_spurious", 64'd1, 64'd0);
        end else if (AXIS_M_TREADY) begin
          e = exp_q.pop_front();
          check("m_beat", cur_m, e);
          obs_tid.push_back(AXIS_M_TID);
          if (e.last) exp_pkt = exp_pkt + 1'b1;
        end
      end
      prev_stall = AXIS_M_TVALID & ~AXIS_M_TREADY;
      prev_snap = cur_m;
      if (AXIS_S_TVALID && AXIS_S_TREADY) begin
        if (!in_pkt) keep = (AXIS_S_TDEST == DESTW'(LD));
        if (keep) exp_q.push_back({AXIS_S_TDATA, AXIS_S_TLAST, AXIS_S_TUSER, AXIS_S_TDEST, fwd_tid});
        if (AXIS_S_TLAST) begin
          if (keep) fwd_tid = fwd_tid + 1'b1;
          else exp_drop = exp_drop + 1'b1;
          in_pkt = 1'b0;
        end else begin
          in_pkt = 1'b1;
        end
      end
    end
  end

  // Counters every cycle; ready must stay high while discarding a packet.
  always @(negedge CLK) begin
    check("pkt_cnt", PKT_CNT, exp_pkt);
    check("drop_cnt", DROP_CNT, exp_drop);
    if (RST_N && in_pkt && !keep) check("s_ready_drop", AXIS_S_TREADY, 1'b1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic reset_dut();
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    AXIS_S_TVALID = 1'b0;
    #1;
    check("rst_m_valid", AXIS_M_TVALID, 1'b0);
    check("rst_m_data", AXIS_M_TDATA, '0);
    check("rst_m_tid", AXIS_M_TID, '0);
    check("rst_pkt_cnt", PKT_CNT, '0);
    check("rst_drop_cnt", DROP_CNT, '0);
    check("rst_s_ready", AXIS_S_TREADY, 1'b0);
    cycles(2);
    #2;
    RST_N = 1'b1;
    cycles(2);
  endtask

  // Offer one beat starting at a negedge; acc reports whether it was taken.
  task automatic send_beat(input logic [DATAW-1:0] d, input logic l, input logic [DESTW-1:0] dst,
                           input int budget, output bit acc);
    logic r;
    AXIS_S_TDATA = d;
    AXIS_S_TLAST = l;
    AXIS_S_TUSER = USERW'($urandom);
    AXIS_S_TDEST = dst;
    AXIS_S_TVALID = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < budget; i++) begin
      r = AXIS_S_TREADY;
      @(posedge CLK);
      if (r) begin
        acc = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    if (acc) @(negedge CLK);
    AXIS_S_TVALID = 1'b0;
  endtask

  task automatic send_pkt(input int len, input logic [DESTW-1:0] head_dest,
                          input logic [DATAW-1:0] base, input int max_gap);
    bit acc;
    logic [DESTW-1:0] dst;
    for (int i = 0; i < len; i++) begin
      dst = (i == 0) ? head_dest : DESTW'($urandom);
      send_beat(base + DATAW'(i), (i == len - 1), dst, 300, acc);
      check("pkt_beat_acc", acc, 1'b1);
      if (max_gap > 0) cycles($urandom_range(0, max_gap));
    end
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (exp_q.size() == 0 && !AXIS_M_TVALID) begin
        done = 1'b1;
        break;
      end
      @(negedge CLK);
    end
    check("drain_timeout", done, 1'b1);
  endtask

  int n0;
  bit acc;
  int n_acc;
  logic [DESTW-1:0] other;

  initial begin
    RST_N = 1'b0;
    AXIS_S_TVALID = 1'b0;
    AXIS_S_TDATA = '0;
    AXIS_S_TLAST = 1'b0;
    AXIS_S_TUSER = '0;
    AXIS_S_TDEST = '0;
    rand_mode = 1'b0;
    m_fixed = 1'b1;

    // Single-beat forward: latency 2, TID 0
    reset_dut();
    send_beat(32'hA5, 1'b1, DESTW'(LD), 10, acc);
    check("t1_acc", acc, 1'b1);
    check("t1_lat_n1", AXIS_M_TVALID, 1'b0);
    @(negedge CLK);
    check("t1_lat_n2", AXIS_M_TVALID, 1'b1);
    check("t1_tdata", AXIS_M_TDATA, 32'hA5);
    check("t1_tid", AXIS_M_TID, 4'd0);
    @(negedge CLK);
    check("t1_pkt_cnt", PKT_CNT, 16'd1);

    // Drop whole packet whose head mismatches; next match gets TID 0
    reset_dut();
    send_beat(32'h11, 1'b0, DESTW'(LD + 1), 1, acc); check("t2_b0", acc, 1'b1);
    send_beat(32'h12, 1'b0, DESTW'(LD), 1, acc);     check("t2_b1", acc, 1'b1);
    send_beat(32'h13, 1'b1, DESTW'(LD), 1, acc);     check("t2_b2", acc, 1'b1);
    cycles(4);
    check("t2_drop_cnt", DROP_CNT, 16'd1);
    check("t2_no_m", AXIS_M_TVALID, 1'b0);
    n0 = obs_tid.size();
    send_pkt(1, DESTW'(LD), 32'h20, 0);
    wait_drain();
    check("t2_nbeats", obs_tid.size() - n0, 1);
    if (obs_tid.size() > n0) check("t2_tid", obs_tid[n0], 4'd0);

    // Backpressure: 16 FIFO beats + 1 output-register beat, then stall
    reset_dut();
    m_fixed = 1'b0;
    n0 = obs_tid.size();
    n_acc = 0;
    for (int i = 0; i < 17; i++) begin
      send_beat(32'h100 + i, (i == 16), DESTW'(LD), 3, acc);
      if (acc) n_acc++;
    end
    check("t3_accepted", n_acc, 17);
    send_beat(32'h200, 1'b1, DESTW'(LD), 10, acc);
    check("t3_18th_blocked", acc, 1'b0);
    check("t3_s_ready_low", AXIS_S_TREADY, 1'b0);
    check("t3_m_valid_held", AXIS_M_TVALID, 1'b1);
    check("t3_m_data_head", AXIS_M_TDATA, 32'h100);
    cycles(5);
    m_fixed = 1'b1;
    wait_drain();
    check("t3_nbeats", obs_tid.size() - n0, 17);

    // Interleaved: forward 4, drop 2, forward 1
    reset_dut();
    n0 = obs_tid.size();
    send_pkt(4, DESTW'(LD), 32'h300, 0);
    send_pkt(2, DESTW'(LD + 7), 32'h400, 0);
    send_pkt(1, DESTW'(LD), 32'h500, 0);
    wait_drain();
    check("t4_nbeats", obs_tid.size() - n0, 5);
    if (obs_tid.size() >= n0 + 5) begin
      for (int i = 0; i < 5; i++) check("t4_tid", obs_tid[n0 + i], (i == 4) ? 4'd1 : 4'd0);
    end
    check("t4_pkt_cnt", PKT_CNT, 16'd2);
    check("t4_drop_cnt", DROP_CNT, 16'd1);

    // Reset mid-packet: partial packet vanishes, next beat is a head
    reset_dut();
    m_fixed = 1'b0;
    send_beat(32'h600, 1'b0, DESTW'(LD), 3, acc); check("t5_b0", acc, 1'b1);
    send_beat(32'h601, 1'b0, DESTW'(LD), 3, acc); check("t5_b1", acc, 1'b1);
    cycles(2);
    check("t5_m_valid_before", AXIS_M_TVALID, 1'b1);
    reset_dut();
    m_fixed = 1'b1;
    send_beat(32'h602, 1'b1, DESTW'(LD + 2), 3, acc); check("t5_acc", acc, 1'b1);
    cycles(3);
    check("t5_drop_cnt", DROP_CNT, 16'd1);
    check("t5_no_m", AXIS_M_TVALID, 1'b0);

    // Sequence counter wrap: 17 packets, TIDs 15 then 0
    reset_dut();
    n0 = obs_tid.size();
    for (int i = 0; i < 17; i++) send_pkt(1, DESTW'(LD), 32'h700 + i, 0);
    wait_drain();
    check("t6_nbeats", obs_tid.size() - n0, 17);
    if (obs_tid.size() >= n0 + 17) begin
      check("t6_tid_max", obs_tid[n0 + 15], 4'd15);
      check("t6_tid_wrap", obs_tid[n0 + 16], 4'd0);
    end

    // Randomized stream with random backpressure and gaps
    reset_dut();
    rand_mode = 1'b1;
    for (int p = 0; p < 60; p++) begin
      other = DESTW'(LD) ^ DESTW'($urandom_range(1, 4095));
      send_pkt($urandom_range(1, 5), ($urandom_range(0, 1) == 1) ? DESTW'(LD) : other,
               DATAW'($urandom), 2);
    end
    wait_drain();
    rand_mode = 1'b0;
    check("end_queue_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
